// File: rtl/alarm_clk_pkg.sv
// Shared time types for the alarm clock blocks: BCD time layout,
// display mode encoding and a BCD range checker.
package alarm_clk_pkg;

  localparam int TIME_W = 20;

  // Bit layout [19:0]: hour tens down to second units.
  typedef struct packed {
    logic [1:0] h_t;
    logic [3:0] h_u;
    logic [2:0] m_t;
    logic [3:0] m_u;
    logic [2:0] s_t;
    logic [3:0] s_u;
  } time_bcd_t;

  typedef enum logic {
    MODE_24H = 1'b0,
    MODE_12H = 1'b1
  } disp_mode_t;

  // True when a 24h time cannot be a real time of day: any units digit
  // above 9, hour tens above 2, or an hour of 24..29.
  function automatic logic time_bcd_bad(input time_bcd_t t);
    return (t.h_u > 4'd9) || (t.m_u > 4'd9) || (t.s_u > 4'd9) ||
           (t.h_t > 2'd2) || ((t.h_t == 2'd2) && (t.h_u > 4'd3));
  endfunction

endpackage

// File: rtl/time_fmt12_24_hour_24to12.sv
// Combinational 24h -> 12h converter for a single BCD time channel.
// Works directly on the hour digits; minutes and seconds pass through.
module hour_24to12
  import alarm_clk_pkg::*;
#(
  parameter bit LEAD_BLANK = 1'b1,
  parameter bit CHECK_BCD  = 1'b1
) (
  input  time_bcd_t  i_time,
  input  disp_mode_t i_mode,
  output time_bcd_t  o_time,
  output logic       o_pm,
  output logic       o_hblank,
  output logic       o_err
);

  logic       w_bad;
  logic [1:0] w_h_t;
  logic [3:0] w_h_u;
  logic       w_pm;

  assign w_bad = CHECK_BCD && time_bcd_bad(i_time);
  assign o_err = w_bad;

  // 12h hour digits: 00->12, 13..19->01..07, 20/21->08/09, 22/23->10/11.
  always_comb begin
    w_h_t = i_time.h_t;
    w_h_u = i_time.h_u;
    w_pm  = 1'b0;
    case (i_time.h_t)
      2'd0: begin
        if (i_time.h_u == 4'd0) begin
          w_h_t = 2'd1;
          w_h_u = 4'd2;
        end
      end
      2'd1: begin
        if (i_time.h_u == 4'd2) begin
          w_pm = 1'b1;
        end else if (i_time.h_u >= 4'd3) begin
          w_h_t = 2'd0;
          w_h_u = i_time.h_u - 4'd2;
          w_pm  = 1'b1;
        end
      end
      2'd2: begin
        w_pm = 1'b1;
        if (i_time.h_u <= 4'd1) begin
          w_h_t = 2'd0;
          w_h_u = i_time.h_u + 4'd8;
        end else begin
          w_h_t = 2'd1;
          w_h_u = i_time.h_u - 4'd2;
        end
      end
      default: ;
    endcase
  end

  // Invalid channels and 24h mode pass the input through untouched.
  always_comb begin
    o_time   = i_time;
    o_pm     = 1'b0;
    o_hblank = 1'b0;
    if ((i_mode == MODE_12H) && !w_bad) begin
      o_time.h_t = w_h_t;
      o_time.h_u = w_h_u;
      o_pm       = w_pm;
      o_hblank   = LEAD_BLANK && (w_h_t == 2'd0);
    end
  end

endmodule

// File: rtl/time_fmt12_24.sv
// Two-stage 12h/24h display formatter for N_CH BCD time channels.
// Stage 1 captures a frame and its mode; stage 2 converts and registers.
//
// Handshake: in_valid and out_valid are single-cycle strobes with no
// backpressure. Each in_valid produces exactly one out_valid two cycles
// later; outputs and mode_act change only on out_valid and hold otherwise.
module time_fmt12_24
  import alarm_clk_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter bit LEAD_BLANK = 1'b1,
  parameter bit CHECK_BCD  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mod12_24,
  input  logic                     in_valid,
  input  logic [TIME_W*N_CH-1:0]   in_disp_time,
  output logic                     out_valid,
  output logic [TIME_W*N_CH-1:0]   out_disp_time,
  output logic [N_CH-1:0]          pm,
  output logic [N_CH-1:0]          hblank,
  output logic [N_CH-1:0]          err,
  output logic                     mode_act
);

  logic                   r_s1_valid;
  disp_mode_t             r_s1_mode;
  logic [TIME_W*N_CH-1:0] r_s1_time;

  logic                   r_out_valid;
  logic [TIME_W*N_CH-1:0] r_out_time;
  logic [N_CH-1:0]        r_pm;
  logic [N_CH-1:0]        r_hblank;
  logic [N_CH-1:0]        r_err;
  disp_mode_t             r_mode_act;

  time_bcd_t              w_conv_time [N_CH];
  logic [TIME_W*N_CH-1:0] w_conv_flat;
  logic [N_CH-1:0]        w_pm;
  logic [N_CH-1:0]        w_hblank;
  logic [N_CH-1:0]        w_err;

  // Stage 1: capture frame and requested mode together, only on in_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= MODE_24H;
      r_s1_time  <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_time <= in_disp_time;
        r_s1_mode <= disp_mode_t'(mod12_24);
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    hour_24to12 #(
      .LEAD_BLANK (LEAD_BLANK),
      .CHECK_BCD  (CHECK_BCD)
    ) u_conv (
      .i_time   (time_bcd_t'(r_s1_time[TIME_W*k +: TIME_W])),
      .i_mode   (r_s1_mode),
      .o_time   (w_conv_time[k]),
      .o_pm     (w_pm[k]),
      .o_hblank (w_hblank[k]),
      .o_err    (w_err[k])
    );
  end

  // Flatten the per-channel converter results back into the port layout.
  always_comb begin
    w_conv_flat = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_conv_flat[TIME_W*k +: TIME_W] = w_conv_time[k];
    end
  end

  // Stage 2: register converted frame; mode_act moves with its frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_time  <= '0;
      r_pm        <= '0;
      r_hblank    <= '0;
      r_err       <= '0;
      r_mode_act  <= MODE_24H;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_time <= w_conv_flat;
        r_pm       <= w_pm;
        r_hblank   <= w_hblank;
        r_err      <= w_err;
        r_mode_act <= r_s1_mode;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_disp_time = r_out_time;
  assign pm            = r_pm;
  assign hblank        = r_hblank;
  assign err           = r_err;
  assign mode_act      = (r_mode_act == MODE_12H);

endmodule

// File: tb/tb_time_fmt12_24.sv
// Scoreboard bench for time_fmt12_24: directed frames from the test plan,
// then randomized frames, checked against an arithmetic reference model.
module tb_time_fmt12_24;
  import alarm_clk_pkg::*;

  localparam int N_CH       = 2;
  localparam bit LEAD_BLANK = 1'b1;
  localparam bit CHECK_BCD  = 1'b1;
  localparam int DW         = TIME_W * N_CH;
  localparam int W          = DW + 3 * N_CH + 1;

  logic            clk;
  logic            reset;
  logic            mod12_24;
  logic            in_valid;
  logic [DW-1:0]   in_disp_time;
  logic            out_valid;
  logic [DW-1:0]   out_disp_time;
  logic [N_CH-1:0] pm;
  logic [N_CH-1:0] hblank;
  logic [N_CH-1:0] err;
  logic            mode_act;

  time_fmt12_24 #(
    .N_CH       (N_CH),
    .LEAD_BLANK (LEAD_BLANK),
    .CHECK_BCD  (CHECK_BCD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mod12_24      (mod12_24),
    .in_valid      (in_valid),
    .in_disp_time  (in_disp_time),
    .out_valid     (out_valid),
    .out_disp_time (out_disp_time),
    .pm            (pm),
    .hblank        (hblank),
    .err           (err),
    .mode_act      (mode_act)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // Expected frame packing: {mode_act, err, hblank, pm, out_disp_time}
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] last_exp;
  int           errors = 0;
  int           checks = 0;

  // ---------------- reference model ----------------
  function automatic logic [19:0] bcd(input int h, input int m, input int s);
    logic [19:0] v;
    v = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    return v;
  endfunction

  // Returns {err, hblank, pm, time} for one channel.
  function automatic logic [22:0] ref_ch(input logic [19:0] t, input logic m12);
    int          ht;
    int          hu;
    int          mu;
    int          su;
    int          h;
    int          h12;
    logic        bad;
    logic        p;
    logic        hb;
    logic [19:0] o;
    ht  = int'(t[19:18]);
    hu  = int'(t[17:14]);
    mu  = int'(t[10:7]);
    su  = int'(t[3:0]);
    h   = ht * 10 + hu;
    bad = CHECK_BCD && (hu > 9 || mu > 9 || su > 9 || ht > 2 || h > 23);
    o   = t;
    p   = 1'b0;
    hb  = 1'b0;
    if (m12 && !bad) begin
      h12 = (h % 12 == 0) ? 12 : (h % 12);
      o[19:18] = 2'(h12 / 10);
      o[17:14] = 4'(h12 % 10);
      p  = (h >= 12);
      hb = LEAD_BLANK && (h12 < 10);
    end
    return {bad, hb, p, o};
  endfunction

  function automatic logic [W-1:0] frame_exp(input logic [DW-1:0] d, input logic m12);
    logic [DW-1:0]   tm;
    logic [N_CH-1:0] p;
    logic [N_CH-1:0] hb;
    logic [N_CH-1:0] er;
    logic [22:0]     r;
    for (int k = 0; k < N_CH; k++) begin
      r = ref_ch(d[TIME_W*k +: TIME_W], m12);
      tm[TIME_W*k +: TIME_W] = r[19:0];
      p[k]  = r[20];
      hb[k] = r[21];
      er[k] = r[22];
    end
    return {m12, er, hb, p, tm};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [DW-1:0] d, input logic m12);
    @(posedge clk);
    #1;
    in_valid     = 1'b1;
    in_disp_time = d;
    mod12_24     = m12;
    exp_q.push_back(frame_exp(d, m12));
    exp_cyc_q.push_back(cyc + 2);
  endtask

  // Idle cycles scramble the data bus and the mode level; neither may matter.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      in_disp_time = DW'({$urandom, $urandom});
      mod12_24     = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic logic [19:0] rand_time();
    if ($urandom_range(0, 7) == 0) return 20'($urandom);
    return bcd($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
  endfunction

  // ---------------- monitor ----------------
  logic [W-1:0] act;
  assign act = {mode_act, err, hblank, pm, out_disp_time};

  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got frame %h, required no out_valid (cycle %0d)", act, cyc);
      end else begin
        logic [W-1:0] e;
        int           c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL frame: got %h, required %h (cycle %0d)", act, e, cyc);
        end
        checks++;
        if (cyc != c) begin
          errors++;
          $display("FAIL latency: got out_valid at cycle %0d, required cycle %0d", cyc, c);
        end
        last_exp = e;
      end
    end else begin
      checks++;
      if (act !== last_exp) begin
        errors++;
        $display("FAIL hold: got %h, required %h (cycle %0d)", act, last_exp, cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [19:0] bad0;
    logic [19:0] bad1;
    int          guard;
    in_valid     = 1'b0;
    mod12_24     = 1'b0;
    in_disp_time = '0;
    last_exp     = '0;
    reset        = 1'b1;
    #1 reset     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Midnight and PM/AM conversions in 12h mode.
    issue({bcd(7, 30, 0), bcd(0, 0, 0)}, 1'b1);
    issue({bcd(12, 0, 5), bcd(13, 45, 30)}, 1'b1);
    // Same time in 24h then 12h.
    issue({bcd(0, 0, 0), bcd(23, 59, 59)}, 1'b0);
    issue({bcd(0, 0, 0), bcd(23, 59, 59)}, 1'b1);
    idle(3);

    // 24h frame, then mode toggling with no strobe must change nothing.
    issue({bcd(22, 10, 0), bcd(11, 11, 11)}, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mod12_24 = ~mod12_24;
    end
    issue({bcd(22, 10, 0), bcd(11, 11, 11)}, 1'b1);
    idle(3);

    // Invalid inputs: 25:00:00 and 09:5A:00, then invalid beside valid.
    bad0 = {2'd2, 4'd5, 3'd0, 4'd0, 3'd0, 4'd0};
    bad1 = {2'd0, 4'd9, 3'd5, 4'd10, 3'd0, 4'd0};
    issue({bad1, bad0}, 1'b1);
    issue({bcd(13, 0, 0), bad0}, 1'b1);
    issue({bcd(21, 5, 9), bcd(20, 0, 1)}, 1'b1);
    idle(3);

    // Randomized frames with random gaps and mode changes.
    for (int i = 0; i < 300; i++) begin
      logic [DW-1:0] d;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      for (int k = 0; k < N_CH; k++) d[TIME_W*k +: TIME_W] = rand_time();
      issue(d, 1'($urandom_range(0, 1)));
    end
    idle(4);

    // Reset during back-to-back strobes discards in-flight frames.
    issue({bcd(1, 2, 3), bcd(14, 0, 0)}, 1'b1);
    issue({bcd(4, 5, 6), bcd(15, 0, 0)}, 1'b1);
    @(posedge clk);
    #1;
    in_valid     = 1'b1;
    in_disp_time = {bcd(7, 8, 9), bcd(16, 0, 0)};
    reset        = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    last_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    idle(6);

    // Recovery after reset.
    issue({bcd(12, 30, 0), bcd(9, 15, 0)}, 1'b1);
    idle(4);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d frames outstanding, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_fmt12_24.md
Name: time_fmt12_24

Overview:
Parametrised, pipelined successor to the 12h/24h display formatter. It converts N_CH BCD time channels (for example current time and alarm time) from 24h format into the selected display format. It raises a per-channel PM flag, optionally blanks the leading hour digit, and flags invalid BCD. Mode changes are applied only on frame boundaries so that all channels in a frame always share one format. It sits between the timekeeping/alarm registers and the 7-segment display driver.

Parameters:
N_CH, 2, number of independent 20-bit time channels (1..8)
LEAD_BLANK, 1, 1 = report hour-tens blanking when in 12h mode and the hour-tens digit is 0
CHECK_BCD, 1, 1 = validate input digits/ranges and drive err; 0 = err tied low

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
mod12_24  in  1  requested mode level: 1 = 12h AM/PM, 0 = 24h
in_valid  in  1  strobe: new frame on in_disp_time
in_disp_time  in  20*N_CH  24h BCD times; channel k at [20k+19:20k]
out_valid  out  1  strobe: new formatted frame on outputs
out_disp_time  out  20*N_CH  formatted BCD times, same layout
pm  out  N_CH  per-channel PM flag (feeds led0 of each display)
hblank  out  N_CH  per-channel blank request for the hour-tens digit
err  out  N_CH  per-channel invalid-input flag
mode_act  out  1  mode currently applied to outputs

Behaviour:
- Channel bit layout: [19:18] hour tens, [17:14] hour units, [13:11] minute tens, [10:7] minute units, [6:4] second tens, [3:0] second units.
- Reset (reset=0, asynchronous): all outputs 0, mode_act=0 (24h), pipeline valid bits cleared. Release is synchronous to clk.
- Stage 1, on the clk edge with in_valid=1:
  - Register all channels.
  - Sample mod12_24 into the frame mode.
  - Compute per-channel validity. A channel is invalid if any units digit >9, or hour >23, or hour tens >2.
  - With in_valid=0, stage-1 data holds and the frame mode does not change.
- Stage 2: convert the stage-1 frame, register the outputs, and update mode_act from the frame mode together with the frame.
- Latency: out_valid pulses exactly 2 cycles after in_valid. Back-to-back in_valid gives back-to-back out_valid, throughput 1 frame/cycle.
- Outputs hold their values between out_valid pulses.
- 12h conversion of hour H, minutes/seconds unchanged:
  - H=00 -> 12, pm=0
  - H=01..11 -> H, pm=0
  - H=12 -> 12, pm=1
  - H=13..21 -> H-12, pm=1
  - H=22 -> 10, pm=1
  - H=23 -> 11, pm=1
- The conversion is done in BCD directly; no binary intermediate.
- 24h mode: output equals input, pm=0, hblank=0.
- hblank=1 only if LEAD_BLANK=1, 12h mode, and the converted hour tens digit is 0.
- Invalid channel: output equals input unchanged, pm=0, hblank=0, err=1. Other channels are unaffected.
- A mod12_24 change between strobes has no effect until the next in_valid. Frames already in the pipeline keep the mode they were sampled with.
- in_valid asserted on the same cycle as a mod12_24 change uses the new mod12_24 value.
- Reset asserted mid-pipeline: in-flight frames are discarded and no out_valid is produced for them.

Decomposition:
- Package alarm_clk_pkg: packed struct time_bcd_t (h_t[1:0], h_u[3:0], m_t[2:0], m_u[3:0], s_t[2:0], s_u[3:0]), localparam TIME_W=20, enum disp_mode_t {MODE_24H=0, MODE_12H=1}. Reuse these in the timekeeper and alarm blocks.
- Sub-module hour_24to12: combinational, one per channel via generate. Inputs: time_bcd_t and mode. Outputs: converted time_bcd_t, pm, hblank, err.
- The top level owns the pipeline registers and the mode_act logic.

Test Plan:
- 12h mode, ch0=00:00:00 -> after 2 cycles out=12:00:00, pm=0, hblank=0, err=0.
- 12h mode, ch0=13:45:30, ch1=12:00:05 -> ch0 01:45:30, pm=1, hblank=1; ch1 12:00:05, pm=1, hblank=0.
- 24h mode, ch0=23:59:59 -> out=23:59:59, pm=0, hblank=0, mode_act=0. Repeat in 12h mode -> 11:59:59, pm=1, hblank=0.
- Toggle mod12_24 0->1 with no in_valid for 10 cycles -> outputs and mode_act unchanged. Next in_valid -> mode_act=1 two cycles later.
- ch0=25:00:00 (h_t=2, h_u=5), ch1=09:5A:00 invalid minute units -> err=2'b11, outputs equal inputs, pm=0. A valid ch at the same time is unaffected.
- in_valid on 3 consecutive cycles, reset pulsed low on cycle 2 -> no out_valid for the in-flight frames; all outputs 0 after reset.
